// File: rtl/rr_input_arbiter_if.sv
// Handshake bundle between two packet sources, the round-robin input arbiter
// and the output_port_lookup stage.
interface rr_input_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] in0_data;
  logic [CTRL_WIDTH-1:0] in0_ctrl;
  logic                  in0_wr;
  logic                  in0_rdy;
  logic [DATA_WIDTH-1:0] in1_data;
  logic [CTRL_WIDTH-1:0] in1_ctrl;
  logic                  in1_wr;
  logic                  in1_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;
  logic [1:0]            overflow_err;

  modport slave (
    input  in0_data, in0_ctrl, in0_wr,
    input  in1_data, in1_ctrl, in1_wr,
    input  out_rdy,
    output in0_rdy, in1_rdy,
    output out_data, out_ctrl, out_wr,
    output overflow_err
  );

  modport master (
    output in0_data, in0_ctrl, in0_wr,
    output in1_data, in1_ctrl, in1_wr,
    output out_rdy,
    input  in0_rdy, in1_rdy,
    input  out_data, out_ctrl, out_wr,
    input  overflow_err
  );
endinterface

// File: rtl/rr_input_arbiter.sv
// Two-input packet arbiter: each input buffers into a private FIFO and whole
// packets are forwarded round-robin, never interleaved.
module rr_input_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               reset_n,
  rr_input_arbiter_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] RDY_MAX  = CNT_W'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic push, input logic pop);
    logic [CNT_W-1:0] res;
    case ({push, pop})
      2'b10:   res = cnt + CNT_W'(1);
      2'b01:   res = cnt - CNT_W'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

  state_t r_state;
  state_t w_state_nxt;
  logic   r_grant;
  logic   w_grant_nxt;
  logic   r_last;
  logic   w_last_nxt;

  logic [WORD_W-1:0]           r_mem [2][FIFO_DEPTH];
  logic [1:0][PTR_W-1:0]       r_wptr;
  logic [1:0][PTR_W-1:0]       r_rptr;
  logic [1:0][CNT_W-1:0]       r_cnt;
  logic [1:0][CNT_W-1:0]       w_cnt_nxt;
  logic [1:0]                  r_rdy;
  logic [1:0]                  r_ovf;
  logic [1:0]                  w_in_wr;
  logic [1:0][WORD_W-1:0]      w_in_word;
  logic [1:0]                  w_full;
  logic [1:0]                  w_nonempty;
  logic [1:0]                  w_push;
  logic [1:0]                  w_pop;

  logic [WORD_W-1:0] w_head_word;
  logic              w_head_is_ctrl;
  logic              w_can_pop;
  logic              w_pop_any;
  logic [WORD_W-1:0] r_out_word;
  logic              r_out_wr;

  assign w_in_wr      = {bus.in1_wr, bus.in0_wr};
  assign w_in_word[0] = {bus.in0_ctrl, bus.in0_data};
  assign w_in_word[1] = {bus.in1_ctrl, bus.in1_data};

  // Head of the granted FIFO; a non-zero ctrl marks a header or end of packet.
  assign w_head_word    = r_mem[r_grant][r_rptr[r_grant]];
  assign w_head_is_ctrl = |w_head_word[WORD_W-1 -: CTRL_WIDTH];
  assign w_can_pop      = bus.out_rdy & w_nonempty[r_grant];
  assign w_pop          = {w_pop_any & r_grant, w_pop_any & ~r_grant};

  // Per-FIFO status; a write to a full FIFO is dropped even if it is popped.
  always_comb begin
    w_full     = 2'b00;
    w_nonempty = 2'b00;
    w_push     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_full[i]     = (r_cnt[i] == FULL_CNT);
      w_nonempty[i] = (r_cnt[i] != '0);
      w_push[i]     = w_in_wr[i] & ~w_full[i];
    end
  end

  // Next occupancy; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < 2; i++) begin
      w_cnt_nxt[i] = cnt_next(r_cnt[i], w_push[i], w_pop[i]);
    end
  end

  // Arbitration FSM: next state, grant, last-served source and pop request.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_pop_any   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_nonempty[~r_last]) begin
          w_grant_nxt = ~r_last;
          w_state_nxt = HDR;
        end else if (w_nonempty[r_last]) begin
          w_grant_nxt = r_last;
          w_state_nxt = HDR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HDR: begin
        if (w_can_pop) begin
          w_pop_any   = 1'b1;
          w_state_nxt = w_head_is_ctrl ? HDR : BODY;
        end else begin
          w_state_nxt = HDR;
        end
      end
      BODY: begin
        if (w_can_pop && w_head_is_ctrl) begin
          w_pop_any   = 1'b1;
          w_last_nxt  = r_grant;
          w_state_nxt = IDLE;
        end else if (w_can_pop) begin
          w_pop_any   = 1'b1;
          w_state_nxt = BODY;
        end else begin
          w_state_nxt = BODY;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM registers; last_served resets to 1 so input 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // FIFO pointers, occupancy, registered ready and sticky overflow flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_rdy  <= 2'b00;
      r_ovf  <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= ptr_inc(r_wptr[i]);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= ptr_inc(r_rptr[i]);
        end
        r_cnt[i] <= w_cnt_nxt[i];
        r_rdy[i] <= (w_cnt_nxt[i] <= RDY_MAX);
        r_ovf[i] <= r_ovf[i] | (w_in_wr[i] & w_full[i]);
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= w_in_word[i];
      end
    end
  end

  // Output register: one valid cycle per popped word, data held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_wr   <= 1'b0;
      r_out_word <= '0;
    end else begin
      r_out_wr <= w_pop_any;
      if (w_pop_any) begin
        r_out_word <= w_head_word;
      end
    end
  end

  assign bus.out_wr       = r_out_wr;
  assign bus.out_data     = r_out_word[DATA_WIDTH-1:0];
  assign bus.out_ctrl     = r_out_word[WORD_W-1 -: CTRL_WIDTH];
  assign bus.in0_rdy      = r_rdy[0];
  assign bus.in1_rdy      = r_rdy[1];
  assign bus.overflow_err = r_ovf;
endmodule

// File: tb/tb_rr_input_arbiter.sv
// Scoreboard bench for rr_input_arbiter: expected words are queued as packets
// are sent and matched against the words captured on the output port.
module tb_rr_input_arbiter;
  localparam int DW    = 64;
  localparam int CW    = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n;

  rr_input_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  rr_input_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } word_t;

  word_t obs[$];
  word_t exp_q[$];
  bit    rdy_hist[int];
  int    cyc   = 0;
  int    n_vec = 0;
  int    n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output word with the cycle it appeared in.
  always @(negedge clk) begin
    rdy_hist[cyc] = bus.out_rdy;
    if (bus.out_wr === 1'b1) obs.push_back('{cyc, bus.out_ctrl, bus.out_data});
  end

  function automatic logic [CW-1:0] mkctrl(input int idx, input int n);
    if (idx == 0) return 8'hFF;
    if (idx == n - 1) return 8'h01;
    return 8'h00;
  endfunction

  function automatic logic [DW-1:0] mkdata(input int src, input int pkt, input int idx);
    return {8'(src), 8'(pkt), 8'(idx), 8'hA5, 32'(src * 4096 + pkt * 64 + idx) ^ 32'h5EED_1234};
  endfunction

  task automatic push_pkt(input int src, input int pkt, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{0, mkctrl(i, n), mkdata(src, pkt, i)});
  endtask

  task automatic set_in(input int src, input logic wr, input logic [CW-1:0] c, input logic [DW-1:0] d);
    if (src == 0) begin
      bus.in0_wr = wr; bus.in0_ctrl = c; bus.in0_data = d;
    end else begin
      bus.in1_wr = wr; bus.in1_ctrl = c; bus.in1_data = d;
    end
  endtask

  // Sends one packet, one word per cycle while the input is ready.
  task automatic send_pkt(input int src, input int pkt, input int n, input bit ign);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!ign && ((src == 0) ? bus.in0_rdy : bus.in1_rdy) !== 1'b1 && guard < 1000) begin
        set_in(src, 1'b0, '0, '0);
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 1000) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: src %0d rdy stuck low, want 1", src);
      end
      set_in(src, 1'b1, mkctrl(i, n), mkdata(src, pkt, i));
      @(posedge clk); #1;
    end
    set_in(src, 1'b0, '0, '0);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int b;
    b = 0;
    while (obs.size() < n && b < budget) begin
      @(negedge clk); #1;
      b++;
    end
    ok = (obs.size() >= n);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    logic [DW-1:0] got [6];
    string         nm  [6];
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = '{DW'(bus.out_wr), bus.out_data, DW'(bus.out_ctrl), DW'(bus.overflow_err),
            DW'(bus.in0_rdy), DW'(bus.in1_rdy)};
    nm  = '{"out_wr", "out_data", "out_ctrl", "overflow_err", "in0_rdy", "in1_rdy"};
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (got[i] !== '0) begin
        n_err++;
        $display("FAIL reset_%s: got %h want 0", nm[i], got[i]);
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({bus.in1_rdy, bus.in0_rdy} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_rdy_rise: got %b want 11", {bus.in1_rdy, bus.in0_rdy});
    end
  endtask

  task automatic test_single();
    int k;
    bit ok;
    obs.delete(); exp_q.delete();
    bus.out_rdy = 1'b1;
    k = cyc;
    push_pkt(0, 1, 4);
    send_pkt(0, 1, 4, 1'b0);
    wait_obs(4, 50, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL single_timeout: got %0d words want 4", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_vec++;
      if (obs[i].ctrl !== exp_q[i].ctrl || obs[i].data !== exp_q[i].data) begin
        n_err++;
        $display("FAIL single_word[%0d]: got %h/%h want %h/%h", i, obs[i].ctrl, obs[i].data,
                 exp_q[i].ctrl, exp_q[i].data);
      end
      n_vec++;
      if (obs[i].cyc !== k + 3 + i) begin
        n_err++;
        $display("FAIL single_latency[%0d]: got cycle %0d want %0d", i, obs[i].cyc, k + 3 + i);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (obs.size() !== 4) begin n_err++; $display("FAIL single_extra: got %0d words want 4", obs.size()); end
  endtask

  task automatic test_contention();
    bit ok;
    bus.out_rdy = 1'b0;
    pulse_reset();
    push_pkt(0, 2, 4);
    push_pkt(1, 2, 4);
    fork
      send_pkt(0, 2, 4, 1'b0);
      send_pkt(1, 2, 4, 1'b0);
    join
    repeat (2) @(posedge clk);
    #1;
    bus.out_rdy = 1'b1;
    wait_obs(8, 100, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL contention_timeout: got %0d words want 8", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_vec++;
      if (obs[i].ctrl !== exp_q[i].ctrl || obs[i].data !== exp_q[i].data) begin
        n_err++;
        $display("FAIL contention_word[%0d]: got %h/%h want %h/%h", i, obs[i].ctrl, obs[i].data,
                 exp_q[i].ctrl, exp_q[i].data);
      end
      if (i > 0) begin
        n_vec++;
        if (obs[i].cyc - obs[i-1].cyc !== ((i == 4) ? 2 : 1)) begin
          n_err++;
          $display("FAIL contention_gap[%0d]: got %0d want %0d", i, obs[i].cyc - obs[i-1].cyc,
                   (i == 4) ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    @(posedge clk); #1;
    obs.delete(); exp_q.delete();
    bus.out_rdy = 1'b0;
    push_pkt(0, 3, 6);
    send_pkt(0, 3, 6, 1'b0);
    for (int t = 0; t < 16; t++) begin
      bus.out_rdy = (t % 2 == 0);
      @(posedge clk); #1;
    end
    bus.out_rdy = 1'b1;
    wait_obs(6, 50, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL bp_timeout: got %0d words want 6", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_vec++;
      if (obs[i].ctrl !== exp_q[i].ctrl || obs[i].data !== exp_q[i].data) begin
        n_err++;
        $display("FAIL bp_word[%0d]: got %h/%h want %h/%h", i, obs[i].ctrl, obs[i].data,
                 exp_q[i].ctrl, exp_q[i].data);
      end
      n_vec++;
      if (rdy_hist[obs[i].cyc - 1] !== 1'b1) begin
        n_err++;
        $display("FAIL bp_rdy_prev[%0d]: got out_rdy %b before word want 1", i, rdy_hist[obs[i].cyc - 1]);
      end
      if (i > 0) begin
        n_vec++;
        if (obs[i].cyc - obs[i-1].cyc !== 2) begin
          n_err++;
          $display("FAIL bp_gap[%0d]: got %0d want 2", i, obs[i].cyc - obs[i-1].cyc);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    @(posedge clk); #1;
    obs.delete(); exp_q.delete();
    bus.out_rdy = 1'b0;
    push_pkt(1, 4, 8);
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) set_in(1, 1'b1, mkctrl(i, DEPTH), mkdata(1, 4, i));
      else           set_in(1, 1'b1, 8'h02, 64'hDEAD_BEEF_0BAD_F00D);
      @(posedge clk); #1;
      n_vec++;
      if (bus.in1_rdy !== ((i + 1) <= DEPTH - 2)) begin
        n_err++;
        $display("FAIL ovf_rdy[occ %0d]: got %b want %b", i + 1, bus.in1_rdy, (i + 1) <= DEPTH - 2);
      end
    end
    set_in(1, 1'b0, '0, '0);
    n_vec++;
    if (bus.overflow_err !== 2'b10) begin n_err++; $display("FAIL ovf_flag: got %b want 10", bus.overflow_err); end
    bus.out_rdy = 1'b1;
    wait_obs(DEPTH, 60, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL ovf_timeout: got %0d words want %0d", obs.size(), DEPTH); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_vec++;
      if (obs[i].ctrl !== exp_q[i].ctrl || obs[i].data !== exp_q[i].data) begin
        n_err++;
        $display("FAIL ovf_word[%0d]: got %h/%h want %h/%h", i, obs[i].ctrl, obs[i].data,
                 exp_q[i].ctrl, exp_q[i].data);
      end
    end
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (obs.size() !== DEPTH) begin n_err++; $display("FAIL ovf_drain_count: got %0d want %0d", obs.size(), DEPTH); end
    n_vec++;
    if (bus.overflow_err !== 2'b10) begin n_err++; $display("FAIL ovf_sticky: got %b want 10", bus.overflow_err); end
    n_vec++;
    if (bus.in1_rdy !== 1'b1) begin n_err++; $display("FAIL ovf_rdy_back: got %b want 1", bus.in1_rdy); end
  endtask

  task automatic test_midreset();
    bit ok;
    int k;
    logic [DW-1:0] got [6];
    obs.delete(); exp_q.delete();
    bus.out_rdy = 1'b0;
    send_pkt(0, 5, 6, 1'b0);
    bus.out_rdy = 1'b1;
    wait_obs(2, 30, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL midrst_timeout: got %0d words want 2", obs.size()); end
    reset_n = 1'b0;
    #1;
    got = '{DW'(bus.out_wr), bus.out_data, DW'(bus.out_ctrl), DW'(bus.overflow_err),
            DW'(bus.in0_rdy), DW'(bus.in1_rdy)};
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (got[i] !== '0) begin n_err++; $display("FAIL midrst_value[%0d]: got %h want 0", i, got[i]); end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    obs.delete();
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (obs.size() !== 0) begin n_err++; $display("FAIL midrst_partial: got %0d words want 0", obs.size()); end
    k = cyc;
    push_pkt(1, 6, 4);
    send_pkt(1, 6, 4, 1'b0);
    wait_obs(4, 50, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL midrst_new_timeout: got %0d words want 4", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_vec++;
      if (obs[i].ctrl !== exp_q[i].ctrl || obs[i].data !== exp_q[i].data || obs[i].cyc !== k + 3 + i) begin
        n_err++;
        $display("FAIL midrst_new[%0d]: got %h/%h @%0d want %h/%h @%0d", i, obs[i].ctrl, obs[i].data,
                 obs[i].cyc, exp_q[i].ctrl, exp_q[i].data, k + 3 + i);
      end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int want;
    bus.out_rdy = 1'b1;
    pulse_reset();
    for (int p = 0; p < 10; p++) begin
      push_pkt(0, 16 + p, 4);
      push_pkt(1, 16 + p, 4);
    end
    fork
      for (int p = 0; p < 10; p++) send_pkt(0, 16 + p, 4, 1'b0);
      for (int q = 0; q < 10; q++) send_pkt(1, 16 + q, 4, 1'b0);
    join
    wait_obs(80, 400, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL fair_timeout: got %0d words want 80", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_vec++;
      if (obs[i].ctrl !== exp_q[i].ctrl || obs[i].data !== exp_q[i].data) begin
        n_err++;
        $display("FAIL fair_word[%0d]: got %h/%h want %h/%h", i, obs[i].ctrl, obs[i].data,
                 exp_q[i].ctrl, exp_q[i].data);
      end
      if (i > 0) begin
        want = (i % 4 == 0) ? 2 : 1;
        n_vec++;
        if (obs[i].cyc - obs[i-1].cyc !== want) begin
          n_err++;
          $display("FAIL fair_gap[%0d]: got %0d want %0d", i, obs[i].cyc - obs[i-1].cyc, want);
        end
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.out_rdy = 1'b0;
    set_in(0, 1'b0, '0, '0);
    set_in(1, 1'b0, '0, '0);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_overflow();
    test_midreset();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rr_input_arbiter.md
RR_INPUT_ARBITER -- requirements
Module: rr_input_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64: data bus width in bits.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8: control bus width in bits.
REQ-003 Parameter FIFO_DEPTH, default 8, power of two, minimum 4: words buffered per input.
REQ-004 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Ports in0_data / in1_data, input, DATA_WIDTH: input word, one per source.
REQ-007 Ports in0_ctrl / in1_ctrl, input, CTRL_WIDTH: input control word.
REQ-008 Ports in0_wr / in1_wr, input, 1: input word valid.
REQ-009 Ports in0_rdy / in1_rdy, output, 1: input may accept words.
REQ-010 Port out_data, output, DATA_WIDTH: word for the output_port_lookup stage.
REQ-011 Port out_ctrl, output, CTRL_WIDTH: control word for the output_port_lookup stage.
REQ-012 Port out_wr, output, 1: output word valid, asserted for one cycle per word.
REQ-013 Port out_rdy, input, 1: downstream may accept a word.
REQ-014 Port overflow_err, output, 2: sticky per-input flag; bit i set when a write to a full FIFO i occurs.

Function
REQ-015 Each input SHALL feed a private FIFO of FIFO_DEPTH words, each word holding {ctrl, data}.
REQ-016 inN_rdy SHALL be 1 while FIFO N occupancy <= FIFO_DEPTH-2. This slack absorbs one write issued in the cycle after rdy falls.
REQ-017 A write when FIFO N is full SHALL be discarded and SHALL set overflow_err[N]. overflow_err[N] clears only on reset.
REQ-018 Packet framing:
- A packet SHALL be one or more words with ctrl != 0 (module headers), then one or more words with ctrl == 0, then one word with ctrl != 0 (end of packet).
REQ-019 State machine states SHALL be IDLE, HDR and BODY.
REQ-020 IDLE transitions:
- If any FIFO is non-empty, the arbiter grants a source and moves to HDR.
- The granted source is the first non-empty FIFO searched from (last_served+1) mod 2.
- last_served resets to 1, so input 0 wins the first tie.
REQ-021 HDR transitions: a popped word with ctrl == 0 moves the machine to BODY; a word with ctrl != 0 keeps it in HDR.
REQ-022 BODY transitions:
- A popped word with ctrl != 0 is end of packet.
- On end of packet, last_served is updated to the granted source and the machine returns to IDLE.
REQ-023 The grant SHALL NOT change mid-packet; words of two packets are never interleaved.
REQ-024 A pop from the granted FIFO SHALL occur in a cycle when out_rdy=1, the FIFO is non-empty, and state is HDR or BODY.
REQ-025 out_data, out_ctrl and out_wr SHALL be registered: a pop in cycle t drives out_wr=1 with that word in cycle t+1. When no pop occurs, out_wr=0 in the next cycle.
REQ-026 Minimum latency from inN_wr with an empty FIFO and IDLE state to out_wr SHALL be 3 cycles: FIFO write, grant, output register.
REQ-027 Throughput: after the grant, one word SHALL be emitted per cycle while out_rdy=1 and data is available; there are no bubbles inside a packet.
REQ-028 Throughput: the IDLE state costs exactly one cycle between packets.
REQ-029 When out_rdy=0, no pop SHALL occur and out_wr SHALL be 0 in the next cycle. The state and FIFO contents SHALL be held.
REQ-030 A FIFO SHALL support a simultaneous write and pop in the same cycle: occupancy is unchanged and no word is lost.
REQ-031 If the granted FIFO goes empty mid-packet, the arbiter SHALL wait in its current state with the grant held.
REQ-032 Occupancy counters SHALL be log2(FIFO_DEPTH)+1 bits wide. Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-033 While reset_n=0, the following SHALL hold:
- State is IDLE.
- Both FIFOs are empty.
- last_served is 1.
- out_wr=0, out_data=0, out_ctrl=0.
- overflow_err=2'b00.
- in0_rdy=in1_rdy=0.
REQ-034 in0_rdy and in1_rdy SHALL rise in the first cycle after reset_n deasserts.
REQ-035 Assertion of reset_n mid-packet SHALL discard all buffered words immediately. No partial packet SHALL be emitted after reset.

Verification
REQ-036 Single packet:
- Stimulus: input 0 sends ctrl FF, then 00, then 00, then 01, with out_rdy=1.
- Response: out_wr high for 4 consecutive cycles starting 3 cycles after the first write, with words in order.
REQ-037 Contention:
- Stimulus: both inputs hold a 4-word packet at reset exit.
- Response: input 0's packet is emitted first, one idle cycle follows, then input 1's packet; words are never interleaved.
REQ-038 Backpressure:
- Stimulus: out_rdy toggles 1,0,1,0 during a packet.
- Response: out_wr=1 only in cycles after an out_rdy=1 cycle; data is identical to the unstalled run.
REQ-039 Overflow:
- Stimulus: out_rdy=0 and input 1 writes FIFO_DEPTH+1 words ignoring in1_rdy.
- Response: in1_rdy drops at occupancy 7, overflow_err=2'b10, and exactly 8 words drain after out_rdy=1.
REQ-040 Mid-packet reset:
- Stimulus: reset_n pulsed low after 2 words of a 6-word packet are output.
- Response: out_wr=0 immediately and all registers hold their reset values; a new packet afterwards passes intact.
REQ-041 Fairness:
- Stimulus: both inputs continuously loaded with 10 packets each.
- Response: the output sequence of sources strictly alternates 0,1,0,1,...
